// File: rtl/mips_mc_if.sv
// Controller <-> datapath bundle for the multicycle MIPS core.
// master = control FSM, slave = datapath / monitor side.
interface mips_mc_if;
    logic [31:0] Instr;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  p_state;
    logic        IorD;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCEn;
    logic        RegDst;
    logic        MemtoReg;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUControl;
    logic        illegal_op;

    modport master (
        input  Instr, zero, mem_ready,
        output p_state, IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, illegal_op
    );

    modport slave (
        output Instr, zero, mem_ready,
        input  p_state, IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, illegal_op
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Main control FSM of the multicycle MIPS datapath, with memory-ready stall,
// illegal-instruction detection and a retired-instruction counter.
//
// state   | meaning
// FETCH   | read instr at PC, PC += 4 (waits for mem_ready)
// DECODE  | branch target into ALUOut, dispatch on opcode
// MEMADR  | lw/sw effective address
// MEMRD   | load data read (waits for mem_ready)
// MEMWB   | load data -> rt
// MEMWR   | store (waits for mem_ready)
// EXECUTE | R-type ALU op
// ALUWB   | ALUOut -> rd
// BRANCH  | beq compare, PC <- target if zero
// ADDIEX  | A + SignImm
// ADDIWB  | ALUOut -> rt
// JUMP    | PC <- jump target
module mips_mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mips_mc_if.master        bus,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    ctrl_t      ctrl_q;
    logic [5:0] opcode, funct;
    logic       r_legal, op_legal, illegal, retire;
    logic       unused_instr;

    assign opcode       = bus.Instr[31:26];
    assign funct        = bus.Instr[5:0];
    assign unused_instr = ^bus.Instr[25:6];

    function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
        logic [2:0] a;
        a = ALU_ADD;
        case (f)
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Moore decode of a state; the FSM registers this for the state it is entering.
    function automatic ctrl_t moore(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write    = 1'b1;
                c.pc_write    = 1'b1;
                c.alu_src_b   = 2'b01;
                c.alu_control = ALU_ADD;
            end
            DECODE: begin
                c.alu_src_b   = 2'b11;
                c.alu_control = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'b10;
                c.alu_control = ALU_ADD;
            end
            MEMRD: c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = alu_for_funct(f);
            end
            ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALU_SUB;
                c.pc_src      = 2'b01;
                c.branch      = 1'b1;
            end
            ADDIWB: c.reg_write = 1'b1;
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign r_legal  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);
    assign op_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                      (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
    assign illegal  = (state_q == DECODE) && (!op_legal || ((opcode == OP_R) && !r_legal));
    assign retire   = (state_q inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP}) ||
                      ((state_q == MEMWR) && bus.mem_ready);

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = r_legal ? EXECUTE : FETCH;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ctrl_q    <= moore(FETCH, 6'd0);
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore(state_d, funct);
            if (retire)
                instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.p_state    = state_q;
    assign bus.IorD       = ctrl_q.iord;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.PCSrc      = ctrl_q.pc_src;
    assign bus.ALUControl = ctrl_q.alu_control;

    // Write enables are held off for the whole reset cycle so an aborted
    // instruction leaves no trace; fetch enables additionally wait for memory.
    assign bus.MemWrite   = ctrl_q.mem_write & ~reset;
    assign bus.RegWrite   = ctrl_q.reg_write & ~reset;
    assign bus.IRWrite    = ctrl_q.ir_write & bus.mem_ready & ~reset;
    assign bus.PCEn       = ((ctrl_q.pc_write & (~ctrl_q.ir_write | bus.mem_ready)) |
                             (ctrl_q.branch & bus.zero)) & ~reset;
    assign bus.illegal_op = illegal & ~reset;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: vector table, hand-written
// stall/reset/wrap sequences and randomized instructions against a path model.
module tb_mips_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:0] instr_cnt;
    logic [3:0]  cnt4;

    mips_mc_if bus ();
    mips_mc_if bus4 ();

    assign bus4.Instr     = bus.Instr;
    assign bus4.zero      = bus.zero;
    assign bus4.mem_ready = bus.mem_ready;

    mips_mc_controller #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .instr_cnt (instr_cnt)
    );

    mips_mc_controller #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus4),
        .instr_cnt (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_cnt;

    logic [15:0] act_out;
    assign act_out = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCEn, bus.RegDst,
                      bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                      bus.PCSrc, bus.ALUControl, bus.illegal_op};

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          cycles;
        int          retire;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Expected output vector for a state, straight from the per-state rules.
    function automatic logic [15:0] exp_out(input int s, input logic mr, input logic z,
                                            input logic [5:0] fn, input logic ill);
        logic iord, mw, irw, pcen, rd, m2r, rw, sa, illo;
        logic [1:0] sb, ps;
        logic [2:0] alu;
        {iord, mw, irw, pcen, rd, m2r, rw, sa, illo} = '0;
        sb = 2'b00; ps = 2'b00; alu = 3'b000;
        case (s)
            0:  begin irw = mr; pcen = mr; sb = 2'b01; alu = 3'b010; end
            1:  begin sb = 2'b11; alu = 3'b010; illo = ill; end
            2:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; alu = exp_alu(fn); end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; alu = 3'b110; ps = 2'b01; pcen = z; end
            9:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pcen = 1'b1; end
            default: ;
        endcase
        return {iord, mw, irw, pcen, rd, m2r, rw, sa, sb, ps, alu, illo};
    endfunction

    // Runs one instruction; each cycle starts just after a negedge.
    task automatic exec_instr(input logic [31:0] ins, input logic z, input int fixed_stall,
                              input int stall_max, output int cycles);
        int path[$];
        logic [5:0] op, fn;
        logic r_ok, ill;
        int stalls;
        op = ins[31:26];
        fn = ins[5:0];
        r_ok = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        case (op)
            6'h23:   path = {0, 1, 2, 3, 4};
            6'h2B:   path = {0, 1, 2, 5};
            6'h00:   if (r_ok) path = {0, 1, 6, 7}; else path = {0, 1};
            6'h04:   path = {0, 1, 8};
            6'h08:   path = {0, 1, 9, 10};
            6'h02:   path = {0, 1, 11};
            default: path = {0, 1};
        endcase
        ill = (path.size() == 2);
        cycles = 0;
        bus.Instr = ins;
        bus.zero  = z;
        foreach (path[i]) begin
            if (path[i] == 0 || path[i] == 3 || path[i] == 5)
                stalls = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(stall_max, 0));
            else
                stalls = 0;
            for (int k = 0; k <= stalls; k++) begin
                if (stalls == 0 && !(path[i] == 0 || path[i] == 3 || path[i] == 5))
                    bus.mem_ready = 1'($urandom);
                else
                    bus.mem_ready = (k == stalls);
                #1;
                chk("p_state", 32'(bus.p_state), 32'(path[i]));
                chk("outputs", 32'(act_out), 32'(exp_out(path[i], bus.mem_ready, z, fn, ill)));
                chk("instr_cnt", instr_cnt, model_cnt);
                chk("cnt4", 32'(cnt4), model_cnt & 32'hF);
                cycles++;
                @(negedge clk);
            end
        end
        if (!ill) model_cnt = model_cnt + 1;
    endtask

    vec_t vecs[14];
    int   cyc;
    logic [31:0] c0;

    initial begin
        vecs[0]  = '{32'h8C080004, 1'b0, 5, 1};   // lw
        vecs[1]  = '{32'hAC080004, 1'b0, 4, 1};   // sw
        vecs[2]  = '{32'h01095020, 1'b0, 4, 1};   // add
        vecs[3]  = '{32'h01095022, 1'b0, 4, 1};   // sub
        vecs[4]  = '{32'h01095024, 1'b0, 4, 1};   // and
        vecs[5]  = '{32'h01095025, 1'b0, 4, 1};   // or
        vecs[6]  = '{32'h0109502A, 1'b0, 4, 1};   // slt
        vecs[7]  = '{32'h21080005, 1'b0, 4, 1};   // addi
        vecs[8]  = '{32'h11090002, 1'b1, 3, 1};   // beq taken
        vecs[9]  = '{32'h11090002, 1'b0, 3, 1};   // beq not taken
        vecs[10] = '{32'h08000010, 1'b0, 3, 1};   // j
        vecs[11] = '{32'h0109503F, 1'b0, 2, 0};   // bad funct
        vecs[12] = '{32'hFC000000, 1'b0, 2, 0};   // bad opcode
        vecs[13] = '{32'h0109502B, 1'b1, 2, 0};   // bad funct near slt

        model_cnt     = 0;
        reset         = 1'b1;
        bus.Instr     = 32'h0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_p_state", 32'(bus.p_state), 32'd0);
        chk("rst_enables", 32'({bus.RegWrite, bus.MemWrite, bus.PCEn, bus.IRWrite}), 32'd0);
        chk("rst_cnt", instr_cnt, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_rel_state", 32'(bus.p_state), 32'd0);
        chk("rst_rel_irwrite", 32'(bus.IRWrite), 32'd1);
        @(negedge clk);
        // The release cycle fetched with mem_ready=1; let the stray "instruction"
        // (Instr=0, funct 0 -> illegal) finish so the FSM is back in FETCH.
        bus.mem_ready = 1'b1;
        #1;
        chk("stray_decode_illegal", 32'(bus.illegal_op), 32'd1);
        @(negedge clk);

        foreach (vecs[i]) begin
            c0 = instr_cnt;
            exec_instr(vecs[i].instr, vecs[i].zero, 0, 0, cyc);
            #1;
            chk("vec_cycles", 32'(cyc), 32'(vecs[i].cycles));
            chk("vec_cnt_delta", instr_cnt - c0, 32'(vecs[i].retire));
        end

        // Reset while in ALUWB aborts the write-back.
        bus.Instr = 32'h01095020;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("aluwb_state", 32'(bus.p_state), 32'd7);
        chk("aluwb_regwrite", 32'(bus.RegWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("aluwb_rst_regwrite", 32'(bus.RegWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_state", 32'(bus.p_state), 32'd0);
        chk("post_rst_cnt", instr_cnt, 32'd0);
        model_cnt = 0;

        for (int n = 0; n < 17; n++)
            exec_instr(32'h08000010, 1'b0, 0, 0, cyc);
        #1;
        chk("wrap_cnt4", 32'(cnt4), 32'd1);
        chk("wrap_cnt32", instr_cnt, 32'd17);

        exec_instr(32'hAC080004, 1'b0, 3, 0, cyc);
        chk("sw_stall_cycles", 32'(cyc), 32'd10);
        exec_instr(32'h8C080004, 1'b0, 2, 0, cyc);
        chk("lw_stall_cycles", 32'(cyc), 32'd9);

        for (int n = 0; n < 80; n++) begin
            logic [5:0]  op, fn;
            logic [31:0] ins;
            logic [5:0]  ops[7];
            logic [5:0]  fns[6];
            ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h00};
            fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h20};
            op = ($urandom_range(7, 0) == 0) ? 6'($urandom) : ops[$urandom_range(6, 0)];
            fn = ($urandom_range(5, 0) == 0) ? 6'($urandom) : fns[$urandom_range(5, 0)];
            ins = {op, 20'($urandom), fn};
            exec_instr(ins, 1'($urandom), -1, 3, cyc);
        end
        #1;
        chk("final_cnt", instr_cnt, model_cnt);
        chk("final_cnt4", 32'(cnt4), model_cnt & 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
